// File: rtl/aes_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : aes_encrypt
// Purpose  : Iterative AES (FIPS-197) block encryptor, one round per clock.
//            Handles AES-128/192/256 using a pre-expanded round-key schedule.
//            The running state is visible on `out` every cycle.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-high reset, restarts encryption
//            in       - 128-bit plaintext, in[127:120] is state byte 0
//            allKeys  - round keys, key 0 in the most significant 128 bits
//            out      - current state, ciphertext once done is high
//            done     - high when out holds the final ciphertext
// Revision : 1.0 - initial release
// ============================================================================
module aes_encrypt #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [127:0]           in,
  input  logic [128*(Nr+1)-1:0]  allKeys,
  output logic [127:0]           out,
  output logic                   done
);

  localparam logic [3:0] c_lastRound = 4'(Nr);

  localparam logic [2047:0] c_sbox = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  // Nk does not change the datapath; it only has to agree with Nr.
  if (Nr != Nk + 6) begin : g_badParams
    $error("aes_encrypt: Nr must equal Nk + 6");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  logic [3:0]   r_round;
  logic [127:0] r_out;
  logic         r_done;

  logic [127:0] w_keys [Nr+1];
  logic [127:0] w_roundKey;
  logic [7:0]   w_sub [16];
  logic [7:0]   w_shift [16];
  logic [127:0] w_shifted;
  logic [127:0] w_mixed;
  logic [127:0] w_next;

  for (genvar r = 0; r <= Nr; r++) begin : g_keys
    assign w_keys[r] = allKeys[128*(Nr+1)-1-128*r -: 128];
  end

  // Byte index i = row + 4*col. ShiftRows moves byte (row, col+row) to (row, col).
  for (genvar i = 0; i < 16; i++) begin : g_bytes
    assign w_sub[i]   = c_sbox[2047 - 8*r_out[127-8*i -: 8] -: 8];
    assign w_shift[i] = w_sub[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
    assign w_shifted[127-8*i -: 8] = w_shift[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_cols
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_shift[4*c];
    assign a1 = w_shift[4*c+1];
    assign a2 = w_shift[4*c+2];
    assign a3 = w_shift[4*c+3];
    assign w_mixed[127-32*c -: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mixed[119-32*c -: 8]    = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mixed[111-32*c -: 8]    = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mixed[103-32*c -: 8]    = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Clamp so the key lookup stays in range once the counter parks at Nr+1.
  assign w_roundKey = w_keys[(r_round > c_lastRound) ? c_lastRound : r_round];
  assign w_next     = ((r_round == c_lastRound) ? w_shifted : w_mixed) ^ w_roundKey;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round <= 4'd0;
      r_out   <= 128'd0;
      r_done  <= 1'b0;
    end else if (r_round == 4'd0) begin
      r_out   <= in ^ w_keys[0];
      r_round <= 4'd1;
    end else if (r_round <= c_lastRound) begin
      r_out   <= w_next;
      r_round <= r_round + 4'd1;
      if (r_round == c_lastRound) begin
        r_done <= 1'b1;
      end
    end
  end

  assign out  = r_out;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encrypt
// Purpose  : Directed testbench for aes_encrypt with AES-128/192/256
//            instances sharing clock, reset and plaintext. Round keys are
//            expanded locally from the FIPS-197 example keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_encrypt;

  logic         clk;
  logic         reset;
  logic [127:0] plain;
  logic [128*11-1:0] keys128;
  logic [128*13-1:0] keys192;
  logic [128*15-1:0] keys256;
  logic [127:0] out128, out192, out256;
  logic         done128, done192, done256;

  int checks = 0;
  int errors = 0;

  logic [2047:0] sboxTab = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  aes_encrypt #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .reset(reset), .in(plain), .allKeys(keys128), .out(out128), .done(done128)
  );
  aes_encrypt #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .reset(reset), .in(plain), .allKeys(keys192), .out(out192), .done(done192)
  );
  aes_encrypt #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .reset(reset), .in(plain), .allKeys(keys256), .out(out256), .done(done256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] subWord(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[31-8*b -: 8] = sboxTab[2047 - 8*x[31-8*b -: 8] -: 8];
    end
    return r;
  endfunction

  // Standard FIPS-197 key expansion; returns 15 round keys, key 0 at MSBs.
  function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] res;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [127:0] c_plain = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_ct192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] c_ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [1919:0] full;
    reset = 1'b1;
    plain = c_plain;
    full = expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    keys128 = full[1919 -: 1408];
    full = expandKey({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    keys192 = full[1919 -: 1664];
    keys256 = expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Run 1: nominal encryption on all three key sizes, then hold.
    edges(2);
    chk("reset_out128", out128, 128'h0);
    chk("reset_done128", {127'h0, done128}, 128'h0);
    chk("reset_out256", out256, 128'h0);
    @(negedge clk) reset = 1'b0;
    edges(1);
    chk("edge1_out128", out128, 128'h00102030405060708090a0b0c0d0e0f0);
    edges(1);
    chk("edge2_out128", out128, 128'h89d810e8855ace682d1843d8cb128fe4);
    edges(8);
    chk("edge10_done128", {127'h0, done128}, 128'h0);
    edges(1);
    chk("edge11_out128", out128, c_ct128);
    chk("edge11_done128", {127'h0, done128}, 128'h1);
    edges(1);
    chk("edge12_done192", {127'h0, done192}, 128'h0);
    edges(1);
    chk("edge13_out192", out192, c_ct192);
    chk("edge13_done192", {127'h0, done192}, 128'h1);
    edges(1);
    chk("edge14_done256", {127'h0, done256}, 128'h0);
    edges(1);
    chk("edge15_out256", out256, c_ct256);
    chk("edge15_done256", {127'h0, done256}, 128'h1);
    edges(20);
    chk("hold_out128", out128, c_ct128);
    chk("hold_out192", out192, c_ct192);
    chk("hold_out256", out256, c_ct256);
    chk("hold_done", {125'h0, done128, done192, done256}, 128'h7);

    // Run 2: asynchronous reset between edges 5 and 6, then a full restart.
    @(negedge clk) reset = 1'b1;
    edges(2);
    @(negedge clk) reset = 1'b0;
    edges(5);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out128", out128, 128'h0);
    chk("async_reset_out256", out256, 128'h0);
    chk("async_reset_done", {125'h0, done128, done192, done256}, 128'h0);
    edges(1);
    @(negedge clk) reset = 1'b0;
    edges(10);
    chk("rerun_edge10_done128", {127'h0, done128}, 128'h0);
    edges(1);
    chk("rerun_edge11_out128", out128, c_ct128);
    chk("rerun_edge11_done128", {127'h0, done128}, 128'h1);

    // Run 3: plaintext changes after edge 1 must not affect the result.
    @(negedge clk) reset = 1'b1;
    edges(2);
    @(negedge clk) reset = 1'b0;
    edges(1);
    plain = 128'h0;
    edges(14);
    chk("isolate_out128", out128, c_ct128);
    chk("isolate_out192", out192, c_ct192);
    chk("isolate_out256", out256, c_ct256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
